// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } uart_state_e;

  localparam int unsigned DataBits    = 8;
  localparam logic        StartBitVal = 1'b0;
  localparam logic        StopBitVal  = 1'b1;
  localparam logic        IdleLevel   = 1'b1;

  // Even parity: the parity bit equals the XOR of all data bits.
  function automatic logic even_parity(input logic [DataBits-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with combinational head output and extra-bit wrapping pointers.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned  AddrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [2**AddrW];
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   fill;
  logic             push_en;
  logic             pop_en;

  assign fill    = wr_ptr_q - rd_ptr_q;
  assign o_full  = (fill == DepthCnt);
  assign o_empty = (fill == '0);
  assign o_head  = mem_q[rd_ptr_q[AddrW-1:0]];

  // Push on full and pop on empty are silently ignored.
  assign push_en = i_push & ~o_full;
  assign pop_en  = i_pop & ~o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_en) mem_q[wr_ptr_q[AddrW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_parity_rx.sv
// Oversampling UART receiver (8 data bits, even parity, 1 stop) feeding a small receive FIFO.
module uart_parity_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 651,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_RX_Serial,
  input  logic       i_RX_Read,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Parity_Err,
  output logic       o_Frame_Err,
  output logic       o_Overrun
);

  localparam int unsigned TickDiv  = (CLKS_PER_BIT / OVERSAMPLE > 0) ?
                                     CLKS_PER_BIT / OVERSAMPLE : 1;
  localparam int unsigned TickW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned SmpW     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BitIdxW  = $clog2(DataBits);

  localparam logic [TickW-1:0]   TickLast = TickW'(TickDiv - 1);
  localparam logic [SmpW-1:0]    SmpLast  = SmpW'(OVERSAMPLE - 1);
  localparam logic [SmpW-1:0]    SmpMid   = SmpW'(OVERSAMPLE / 2);
  localparam logic [SmpW-1:0]    SmpEarly = SmpMid - 1'b1;
  localparam logic [SmpW-1:0]    SmpLate  = SmpMid + 1'b1;
  localparam logic [BitIdxW-1:0] BitLast  = BitIdxW'(DataBits - 1);

  // Input synchronizer and free-running sample tick
  logic             rx_meta_q, rx_sync_q;
  logic [TickW-1:0] tick_cnt_q;
  logic             tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= IdleLevel;
      rx_sync_q <= IdleLevel;
    end else begin
      rx_meta_q <= i_RX_Serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign tick = (tick_cnt_q == TickLast);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // Receive FSM
  uart_state_e           state_q, state_d;
  logic [SmpW-1:0]       sidx_q, sidx_d;
  logic [BitIdxW-1:0]    bidx_q, bidx_d;
  logic [DataBits-1:0]   shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic                  smp_a_q, smp_a_d;
  logic                  smp_b_q, smp_b_d;
  logic                  prev_q, prev_d;
  logic                  armed_q, armed_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic [SmpW-1:0]       cur_idx;
  logic                  bit_val;
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DataBits:0]     fifo_head;

  assign cur_idx = (sidx_q == SmpLast) ? '0 : sidx_q + 1'b1;
  // Majority of the two stored mid-bit samples and the current one
  assign bit_val = (smp_a_q & smp_b_q) | (smp_a_q & rx_sync_q) | (smp_b_q & rx_sync_q);

  always_comb begin
    state_d     = state_q;
    sidx_d      = sidx_q;
    bidx_d      = bidx_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    smp_a_d     = smp_a_q;
    smp_b_d     = smp_b_q;
    prev_d      = prev_q;
    armed_d     = armed_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    fifo_push   = 1'b0;

    if (tick) begin
      prev_d = rx_sync_q;
      // A line held low through reset must be seen high once before any start counts.
      if (rx_sync_q) armed_d = 1'b1;
      sidx_d = cur_idx;
      if (cur_idx == SmpEarly) smp_a_d = rx_sync_q;
      if (cur_idx == SmpMid)   smp_b_d = rx_sync_q;

      case (state_q)
        StIdle: begin
          sidx_d = '0;
          if (!rx_sync_q && prev_q && armed_q) begin
            state_d = StStart;
            bidx_d  = '0;
          end
        end
        StStart: begin
          if (cur_idx == SmpLate && bit_val != StartBitVal) begin
            state_d = StIdle;
          end else if (cur_idx == SmpLast) begin
            state_d = StData;
          end
        end
        StData: begin
          if (cur_idx == SmpLate) shift_d = {bit_val, shift_q[DataBits-1:1]};
          if (cur_idx == SmpLast) begin
            bidx_d = bidx_q + 1'b1;
            if (bidx_q == BitLast) state_d = StParity;
          end
        end
        StParity: begin
          if (cur_idx == SmpLate) perr_d = bit_val ^ even_parity(shift_q);
          if (cur_idx == SmpLast) state_d = StStop;
        end
        StStop: begin
          if (cur_idx == SmpLate) begin
            if (bit_val == StopBitVal) begin
              state_d = StIdle;
              if (fifo_full) overrun_d = 1'b1;
              else           fifo_push = 1'b1;
            end else begin
              state_d     = StWaitHigh;
              frame_err_d = 1'b1;
            end
          end
        end
        StWaitHigh: begin
          if (rx_sync_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      sidx_q      <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      smp_a_q     <= 1'b0;
      smp_b_q     <= 1'b0;
      prev_q      <= IdleLevel;
      armed_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sidx_q      <= sidx_d;
      bidx_q      <= bidx_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      smp_a_q     <= smp_a_d;
      smp_b_q     <= smp_b_d;
      prev_q      <= prev_d;
      armed_q     <= armed_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH (DataBits + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push),
    .i_wdata ({perr_q, shift_q}),
    .i_pop   (i_RX_Read),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_head  (fifo_head)
  );

  assign o_RX_DV         = ~fifo_empty;
  assign o_RX_Byte       = fifo_head[DataBits-1:0];
  assign o_RX_Parity_Err = fifo_head[DataBits];
  assign o_Frame_Err     = frame_err_q;
  assign o_Overrun       = overrun_q;

endmodule

// File: tb/tb_uart_parity_rx.sv
// Randomized bench for uart_parity_rx against a queue-based frame model.
`timescale 1ns / 1ps
module tb_uart_parity_rx;

  localparam int unsigned ClksPerBit = 160;
  localparam int unsigned Depth      = 4;

  logic       i_clk       = 1'b0;
  logic       i_rst_n     = 1'b0;
  logic       i_RX_Serial = 1'b1;
  logic       i_RX_Read   = 1'b0;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Parity_Err;
  logic       o_Frame_Err;
  logic       o_Overrun;

  int n_checks = 0;
  int n_errors = 0;
  int fe_seen  = 0;
  int ov_seen  = 0;
  int exp_fe   = 0;
  int exp_ov   = 0;
  logic [8:0] exp_q[$];

  uart_parity_rx #(
    .CLKS_PER_BIT (ClksPerBit),
    .OVERSAMPLE   (16),
    .FIFO_DEPTH   (Depth)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_RX_Serial     (i_RX_Serial),
    .i_RX_Read       (i_RX_Read),
    .o_RX_DV         (o_RX_DV),
    .o_RX_Byte       (o_RX_Byte),
    .o_RX_Parity_Err (o_RX_Parity_Err),
    .o_Frame_Err     (o_Frame_Err),
    .o_Overrun       (o_Overrun)
  );

  always #5 i_clk = ~i_clk;

  // Count high cycles so a stretched pulse shows up as an extra event.
  always @(negedge i_clk) begin
    if (o_Frame_Err === 1'b1) fe_seen++;
    if (o_Overrun === 1'b1)   ov_seen++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic drive_bit(input logic b);
    i_RX_Serial = b;
    idle_clks(ClksPerBit);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(par);
    drive_bit(stop);
    i_RX_Serial = 1'b1;
  endtask

  // Reference: good stop stores {parity error, data} unless already Depth entries.
  task automatic model_frame(input logic [7:0] data, input logic par, input logic stop);
    if (!stop) exp_fe++;
    else if (exp_q.size() >= Depth) exp_ov++;
    else exp_q.push_back({par ^ (^data), data});
  endtask

  task automatic rx_frame(input logic [7:0] data, input logic par, input logic stop);
    send_frame(data, par, stop);
    model_frame(data, par, stop);
  endtask

  task automatic check_pulses(input string tag);
    check_eq({tag, "_frame_err_cnt"}, fe_seen, exp_fe);
    check_eq({tag, "_overrun_cnt"}, ov_seen, exp_ov);
  endtask

  task automatic drain(input string tag);
    logic [8:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge i_clk);
      check_eq({tag, "_dv"}, o_RX_DV, 1);
      check_eq({tag, "_byte"}, o_RX_Byte, e[7:0]);
      check_eq({tag, "_perr"}, o_RX_Parity_Err, e[8]);
      i_RX_Read = 1'b1;
      @(negedge i_clk);
      i_RX_Read = 1'b0;
    end
    @(negedge i_clk);
    check_eq({tag, "_empty"}, o_RX_DV, 0);
    // A read on an empty FIFO must be ignored.
    i_RX_Read = 1'b1;
    @(negedge i_clk);
    i_RX_Read = 1'b0;
    @(negedge i_clk);
    check_eq({tag, "_empty_read"}, o_RX_DV, 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;

    // Reset
    idle_clks(5);
    check_eq("rst_dv", o_RX_DV, 0);
    check_eq("rst_fe", o_Frame_Err, 0);
    check_eq("rst_ov", o_Overrun, 0);
    i_rst_n = 1'b1;
    idle_clks(3 * ClksPerBit);
    check_eq("post_rst_dv", o_RX_DV, 0);
    check_pulses("post_rst");

    // Good frame
    rx_frame(8'hA5, 1'b0, 1'b1);
    @(negedge i_clk);
    check_eq("a5_dv", o_RX_DV, 1);
    check_eq("a5_byte", o_RX_Byte, 8'hA5);
    check_eq("a5_perr", o_RX_Parity_Err, 0);
    drain("a5");

    // Wrong parity
    rx_frame(8'h01, 1'b0, 1'b1);
    @(negedge i_clk);
    check_eq("p01_perr", o_RX_Parity_Err, 1);
    drain("p01");

    // Bad stop followed by a long break
    send_frame(8'h3C, 1'b0, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b0);
    i_RX_Serial = 1'b0;
    idle_clks(20 * ClksPerBit);
    check_eq("break_fe_cnt", fe_seen, 1);
    check_eq("break_dv", o_RX_DV, 0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check_eq("break_dv_high", o_RX_DV, 0);
    rx_frame(8'h55, 1'b0, 1'b1);
    check_pulses("break");
    drain("after_break");

    // Overrun
    for (int i = 0; i < 5; i++) begin
      d = 8'h10 + 8'(i);
      rx_frame(d, ^d, 1'b1);
    end
    check_eq("ovr_pulses", ov_seen, 1);
    check_pulses("ovr");
    drain("ovr");

    // Short glitch on idle line
    i_RX_Serial = 1'b0;
    idle_clks(40);
    i_RX_Serial = 1'b1;
    idle_clks(3 * ClksPerBit);
    check_eq("glitch_dv", o_RX_DV, 0);
    check_pulses("glitch");

    // Reset in the middle of data bit 3 of 0x77, line still low at release
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    i_RX_Serial = 1'b0;
    idle_clks(80);
    i_rst_n = 1'b0;
    idle_clks(5);
    check_eq("midrst_dv", o_RX_DV, 0);
    i_rst_n = 1'b1;
    idle_clks(ClksPerBit);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    fe_seen = 0;
    ov_seen = 0;
    exp_fe  = 0;
    exp_ov  = 0;
    rx_frame(8'h88, 1'b0, 1'b1);
    check_pulses("midrst");
    drain("midrst");

    // Randomized frames with random gaps, parity/stop faults and read timing
    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom_range(0, 255));
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 7) != 0);
      idle_clks($urandom_range(0, 300));
      rx_frame(d, p, s);
      if (!s) begin
        i_RX_Serial = 1'b0;
        idle_clks($urandom_range(1, 3) * ClksPerBit);
        drive_bit(1'b1);
      end
      check_pulses("rnd");
      @(negedge i_clk);
      check_eq("rnd_dv", o_RX_DV, exp_q.size() > 0);
      if ($urandom_range(0, 2) == 0) drain("rnd");
    end
    drain("rnd_final");
    check_pulses("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_parity_rx.md
UART_PARITY_RX -- requirements
Module: uart_parity_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 651, meaning i_clk cycles per serial bit.
REQ-002 Parameter OVERSAMPLE, default 16, meaning sample ticks per bit.
REQ-003 Parameter FIFO_DEPTH, default 16, meaning received-entry capacity, a power of two.
REQ-004 Port i_clk  input  1  sole clock; all logic rising-edge.
REQ-005 Port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 Port i_RX_Serial  input  1  asynchronous serial line, idle high.
REQ-007 Port i_RX_Read  input  1  pop head FIFO entry.
REQ-008 Port o_RX_DV  output  1  FIFO not empty.
REQ-009 Port o_RX_Byte  output  8  head entry data.
REQ-010 Port o_RX_Parity_Err  output  1  head entry parity-error flag.
REQ-011 Port o_Frame_Err  output  1  one-cycle pulse on bad stop bit.
REQ-012 Port o_Overrun  output  1  one-cycle pulse when a good frame is dropped on full FIFO.

Function
REQ-013 Frame SHALL be: start(0), 8 data LSB first, even parity bit (XOR of data), stop(1).
REQ-014 i_RX_Serial SHALL pass a 2-flop synchronizer, reset value 1; all decisions use the synchronized line.
REQ-015 Sample tick SHALL pulse once every CLKS_PER_BIT/OVERSAMPLE clocks (integer division), free-running from reset.
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; all transitions occur only on sample ticks, except reset.
REQ-017 IDLE: on a tick where the line is 0 and the previous tick's sample was 1, go to START with sample index 0.
REQ-018 Each bit value SHALL be the majority of the samples at indices 7, 8 and 9 of that bit; the index wraps 15->0 at each bit boundary.
REQ-019 START: majority 1 returns to IDLE (glitch); majority 0 continues to DATA at the next bit boundary.
REQ-020 DATA: shift the decided bit into bit 7 of the shift register, right-shifting; after 8 bits go to PARITY.
REQ-021 PARITY: parity error = received bit XOR (XOR of data); go to STOP.
REQ-022 STOP: decision at sample index 9; stop=1 with FIFO not full writes {parity error, data} and goes to IDLE.
REQ-023 STOP: stop=1 with FIFO full drops the frame, pulses o_Overrun, and leaves FIFO contents unchanged.
REQ-024 STOP: stop=0 writes nothing, pulses o_Frame_Err, and goes to WAIT_HIGH.
REQ-025 WAIT_HIGH SHALL return to IDLE on the first tick sampling 1 (break handling).
REQ-026 A written entry SHALL be visible on o_RX_DV/o_RX_Byte/o_RX_Parity_Err the clock after the write.
REQ-027 Outputs SHALL be combinational from the head entry; i_RX_Read with FIFO empty SHALL be ignored.
REQ-028 Simultaneous write and read in one clock SHALL both take effect, occupancy unchanged.
REQ-029 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full means pointer difference = FIFO_DEPTH.

Reset
REQ-030 Reset SHALL clear: state to IDLE, pointers, sample/bit indices, tick counter, and error pulses; synchronizer and previous-sample register go to 1.
REQ-031 During and after reset o_RX_DV, o_Frame_Err and o_Overrun SHALL be 0, and o_RX_Byte SHALL be the contents of FIFO location 0.
REQ-032 Reset mid-frame SHALL discard the partial frame; if the line is low at release, no start SHALL be detected until a 1 is sampled.

Structure
REQ-033 The state enum and parity/frame constants SHALL live in shared package uart_pkg, reused by the transmitter.
REQ-034 The FIFO SHALL be sub-module uart_sync_fifo (parameters WIDTH=9, DEPTH), with push/pop/full/empty/head ports.

Verification (CLKS_PER_BIT=160, OVERSAMPLE=16, FIFO_DEPTH=4)
REQ-035 Drive 0xA5, parity 0 -> o_RX_DV=1, o_RX_Byte=0xA5, o_RX_Parity_Err=0; i_RX_Read pulse -> o_RX_DV=0.
REQ-036 Drive 0x01 with parity 0 -> entry 0x01 stored, o_RX_Parity_Err=1.
REQ-037 Drive 0x3C with stop=0, then line low for 20 bits -> one o_Frame_Err pulse, no entry, no new start until the line goes high; next 0x55 is received correctly.
REQ-038 Drive 5 frames 0x10..0x14 without reads -> 4 entries 0x10..0x13, one o_Overrun pulse; reads return them in order.
REQ-039 Drive a 40-clock low glitch on the idle line -> return to IDLE, no entry, no error pulse.
REQ-040 Assert i_rst_n=0 mid-data-bit of 0x77, release, drive 0x88 -> only 0x88 in FIFO.
